// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the input debounce path:
//   - debounce_state_t : FSM state type with fixed encodings
//   - DEFAULT_STABLE_CYCLES / DEFAULT_CNT_W / DEFAULT_GLITCH_W : default sizing
//   - state_level()    : stable level that a given state represents
// ---------------------------------------------------------------------------
package debounce_pkg;

  // The encoding is fixed so that bit 1 always gives the current stable
  // level. Bit 0 is set while a change to the opposite level is being
  // qualified.
  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_QUAL_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_QUAL_LOW  = 2'b11
  } debounce_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 16;
  localparam int DEFAULT_CNT_W         = 5;
  localparam int DEFAULT_GLITCH_W      = 8;

  // This is the level that was last accepted while in state s. During
  // qualification the old level is still the valid one.
  function automatic logic state_level(input debounce_state_t s);
    return (s == ST_HIGH) || (s == ST_QUAL_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// This is a 1-bit two-flop synchroniser for asynchronous inputs. Both flops
// reset synchronously to 0.
//
// Ports:
//   clk    input  1  destination clock
//   reset  input  1  synchronous, active-high reset
//   d      input  1  asynchronous input
//   q      output 1  synchronised output, two clk edges after d
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1;

  // The first flop may go metastable. The second flop gives it one full
  // clock period to resolve before anything downstream sees the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//
// This block conditions a raw, bouncy asynchronous input for the edge-detect
// path. The input is first synchronised. A new level is accepted only after
// STABLE_CYCLES consecutive synchronised samples at that level. The block
// then presents a clean level together with a one-cycle change strobe.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a level (2..2^CNT_W-1)
//   CNT_W          qualification counter width (2^CNT_W > STABLE_CYCLES)
//   GLITCH_W       glitch counter width (only with DEBOUNCE_GLITCH_CNT_EN)
//
// Ports:
//   clk         input  1         block clock, rising edge
//   reset       input  1         synchronous, active-high reset
//   in          input  1         raw asynchronous input
//   level_out   output 1         debounced level
//   changed     output 1         one-cycle strobe when level_out toggles
//   glitch_cnt  output GLITCH_W  saturating count of rejected transitions
//                                (only with DEBOUNCE_GLITCH_CNT_EN)
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN
// ---------------------------------------------------------------------------
module input_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  parameter int GLITCH_W      = DEFAULT_GLITCH_W
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  output logic                level_out,
  output logic                changed
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  // The counter already holds 1 when the first qualifying sample enters a
  // qualify state. Qualification therefore completes on the sample that
  // arrives while the counter reads STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            sync_in;
  debounce_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic            level_next;
  logic            changed_next;

  // Only this synchronised copy of the raw pin feeds the FSM.
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (sync_in)
  );

  // State register. level_out and changed are registered here as well, so
  // the downstream edge detector sees glitch-free outputs straight from
  // flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOW;
      cnt       <= '0;
      level_out <= 1'b0;
      changed   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      level_out <= level_next;
      changed   <= changed_next;
    end
  end

  // Next-state logic. A sample that differs from the stable level starts a
  // qualification. A sample back at the old level abandons it. The stable
  // level moves only when the final required sample still agrees with the
  // new level. If a bounce lands in the completing cycle, the sampled value
  // decides whether the change is accepted or rejected.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = level_out;
    changed_next = 1'b0;

    unique case (state)
      ST_LOW: begin
        if (sync_in) begin
          state_next = ST_QUAL_HIGH;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next   = '0;
        end
      end

      ST_QUAL_HIGH: begin
        if (!sync_in) begin
          state_next = ST_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = ST_HIGH;
          level_next   = 1'b1;
          changed_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (!sync_in) begin
          state_next = ST_QUAL_LOW;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next   = '0;
        end
      end

      ST_QUAL_LOW: begin
        if (sync_in) begin
          state_next = ST_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = ST_LOW;
          level_next   = 1'b0;
          changed_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_LOW;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch_evt;

  // A glitch is a return to the old stable level during a qualification,
  // which is the same as sync_in matching state_level() while qualifying.
  // A qualification cut short by reset is not a glitch, because reset takes
  // priority in the counter update below.
  assign glitch_evt = state[0] && (sync_in == state_level(state));

  // The glitch counter saturates at all ones, so a large count stays large
  // and never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt <= '0;
    end else if (glitch_evt && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//
// This is a self-checking bench for input_debounce with STABLE_CYCLES=4.
// A directed sequence is followed by randomised bursts. All outputs are
// compared every cycle against a reference model built from the debounce
// rules: a level is accepted after STABLE_CYCLES consecutive differing
// samples, and any broken run counts as a glitch. The optional glitch
// counter is checked when DEBOUNCE_GLITCH_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_input_debounce;

  localparam int SC = 4;
  localparam int CW = 3;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam int GW   = 2;
  localparam int GMAX = (1 << GW) - 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic din   = 1'b0;
  logic level_out;
  logic changed;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GW-1:0] glitch_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  // Reference model state. The sync stages are modelled only as a two-deep
  // sample delay.
  bit m_sync1, m_sync2, m_level, m_changed;
  int m_run;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  int m_glitch;
`endif

  always #5 clk = ~clk;

  input_debounce #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .GLITCH_W      (GW)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .level_out (level_out),
    .changed   (changed)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  // Compare all DUT outputs against the reference model.
  task automatic checkOutput(input string tag);
    vectors++;
    assert (level_out === m_level) else begin
      miscompares++;
      $error("[TB] FAIL %s level_out got %b want %b", tag, level_out, m_level);
    end
    vectors++;
    assert (changed === m_changed) else begin
      miscompares++;
      $error("[TB] FAIL %s changed got %b want %b", tag, changed, m_changed);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    vectors++;
    assert (glitch_cnt === GW'(m_glitch)) else begin
      miscompares++;
      $error("[TB] FAIL %s glitch_cnt got %0d want %0d", tag, glitch_cnt, m_glitch);
    end
`endif
  endtask

  // Compare one observed value against a fixed value taken from the
  // scenario description.
  task automatic checkConst(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle and advance the model by one rising edge. Then check the
  // outputs #1 after that edge.
  task automatic applyStimulus(input bit v, input bit r, input string tag);
    bit s;
    @(negedge clk);
    din   = v;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_sync1 = 0; m_sync2 = 0; m_level = 0; m_changed = 0; m_run = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      m_glitch = 0;
`endif
    end else begin
      s         = m_sync2;
      m_sync2   = m_sync1;
      m_sync1   = v;
      m_changed = 0;
      if (s != m_level) begin
        m_run++;
        if (m_run == SC) begin
          m_level   = s;
          m_changed = 1;
          m_run     = 0;
        end
      end else begin
`ifdef DEBOUNCE_GLITCH_CNT_EN
        if (m_run > 0 && m_glitch < GMAX) m_glitch++;
`endif
        m_run = 0;
      end
    end
    #1;
    if (changed === 1'b1) pulses++;
    checkOutput(tag);
  endtask

  initial begin
    bit v;
    int len;

    // Reset state
    applyStimulus(0, 1, "reset");
    applyStimulus(0, 1, "reset");
    checkConst("reset_level", level_out, 0);
    checkConst("reset_changed", changed, 0);
    applyStimulus(0, 0, "idle");
    applyStimulus(0, 0, "idle");

    // Clean rise: in is high from before edge 0, level rises after edge 5
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, "rise");
      if (i == 4) checkConst("rise_early_level", level_out, 0);
      if (i == 5) begin
        checkConst("rise_lat_level", level_out, 1);
        checkConst("rise_lat_changed", changed, 1);
      end
      if (i == 6) checkConst("rise_changed_clear", changed, 0);
    end
    checkConst("rise_pulses", pulses, 1);

    // Clean fall after high
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, "fall");
      if (i == 5) checkConst("fall_lat_level", level_out, 0);
    end
    checkConst("fall_pulses", pulses, 1);

    // Bounce rejection
    applyStimulus(0, 1, "reset");
    pulses = 0;
    applyStimulus(1, 0, "bounce");
    applyStimulus(1, 0, "bounce");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, "bounce");
    checkConst("bounce_pulses", pulses, 0);
    checkConst("bounce_level", level_out, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkConst("bounce_glitch", glitch_cnt, 1);
`endif

    // Bounce then settle
    applyStimulus(0, 1, "reset");
    pulses = 0;
    applyStimulus(1, 0, "settle");
    applyStimulus(0, 0, "settle");
    applyStimulus(1, 0, "settle");
    applyStimulus(0, 0, "settle");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, "settle");
    checkConst("settle_pulses", pulses, 1);
    checkConst("settle_level", level_out, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkConst("settle_glitch", glitch_cnt, 2);
`endif

    // Reset during qualification, with cnt=2 after the fourth edge
    applyStimulus(0, 1, "reset");
    applyStimulus(0, 0, "idle");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, "midq");
    applyStimulus(1, 1, "midq_reset");
    checkConst("midq_level", level_out, 0);
    checkConst("midq_changed", changed, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkConst("midq_glitch", glitch_cnt, 0);
`endif
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 0, "midq_rel");
      if (i == 4) checkConst("midq_rel_early", level_out, 0);
      if (i == 5) checkConst("midq_rel_level", level_out, 1);
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Glitch saturation: five rejected pulses with a 2-bit counter
    applyStimulus(0, 1, "reset");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1, 0, "sat");
      applyStimulus(1, 0, "sat");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, "sat");
    end
    checkConst("sat_glitch", glitch_cnt, 3);
`endif

    // Randomised bursts of varying length, with occasional resets
    applyStimulus(0, 1, "reset");
    for (int b = 0; b < 80; b++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) applyStimulus(v, 1'b0, "rand");
      if ($urandom_range(0, 15) == 0) applyStimulus(v, 1'b1, "rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
